dmem_responder: RTL and testbench

Data-memory responder for the RISC-V core's load/store port. It accepts one request at a time over a valid/ready handshake, inserts a fixed number of wait states, and performs a byte-enabled write or a word read on an internal word array. It returns the result over a second valid/ready handshake. It sits between the datapath's data-memory interface (address = ALU result, store data, write strobe) and the core's stall logic, and replaces the zero-latency data memory.

---
 rtl/dmem_responder_if.sv | 40 ++++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request and response handshake between the core and the data-memory responder.
// The master side issues requests and consumes responses; the slave side serves them.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_addr,
        output req_we,
        output req_be,
        output req_wdata,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_addr,
        input  req_we,
        input  req_be,
        input  req_wdata,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states, byte-enabled word array.
// Responses are registered and held until the core completes the response handshake.
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH) << 2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic             access;
    logic             mem_we;

    assign idx     = addr_q[IDX_W+1:2];
    assign acc_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q} >= ADDR_LIMIT);
    assign access  = (state_q == StWait) && (cnt_q == 4'd0);
    // State is reset asynchronously, so a store caught by reset never reaches its access edge.
    assign mem_we  = access && we_q && !acc_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    we_d    = bus.req_we;
                    be_d    = bus.req_be;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = (!we_q && !acc_err) ? mem_q[idx] : 32'h0;
                    err_d   = acc_err;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance driven from a vector table and
// corner-case sequences, plus a WAIT_CYCLES=0 instance for latency and throughput.
module tb_dmem_responder;

    logic clk;
    logic rst_n;

    logic        sel;  // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance
    logic        t_valid;
    logic        t_ready;
    logic [31:0] t_addr;
    logic        t_we;
    logic [3:0]  t_be;
    logic [31:0] t_wdata;

    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    int n_total;
    int n_pass;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    assign bus2.req_valid = t_valid & ~sel;
    assign bus2.rsp_ready = t_ready & ~sel;
    assign bus2.req_addr  = t_addr;
    assign bus2.req_we    = t_we;
    assign bus2.req_be    = t_be;
    assign bus2.req_wdata = t_wdata;

    assign bus0.req_valid = t_valid & sel;
    assign bus0.rsp_ready = t_ready & sel;
    assign bus0.req_addr  = t_addr;
    assign bus0.req_we    = t_we;
    assign bus0.req_be    = t_be;
    assign bus0.req_wdata = t_wdata;

    assign o_req_ready = sel ? bus0.req_ready : bus2.req_ready;
    assign o_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
    assign o_rsp_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
    assign o_rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;

    dmem_responder #(
        .DEPTH       (256),
        .WAIT_CYCLES (2)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    dmem_responder #(
        .DEPTH       (256),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; checks accept, latency, response payload and return to idle.
    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input bit early_ready);
        int lat;
        check({name, ".req_ready_idle"}, 32'(o_req_ready), 32'd1);
        t_we    = we;
        t_addr  = addr;
        t_be    = be;
        t_wdata = wdata;
        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        t_ready = early_ready;
        check({name, ".req_ready_busy"}, 32'(o_req_ready), 32'd0);
        lat = 0;
        while (!o_rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({name, ".latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
        if (o_rsp_valid) begin
            check({name, ".rdata"}, o_rsp_rdata, exp_rdata);
            check({name, ".err"}, 32'(o_rsp_err), 32'(exp_err));
            t_ready = 1'b1;
            tick();
            t_ready = 1'b0;
            check({name, ".idle_after"}, {30'd0, o_req_ready, o_rsp_valid}, 32'd2);
            check({name, ".clear_after"}, o_rsp_rdata | 32'(o_rsp_err), 32'd0);
        end
        t_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int hs;
        n_total = 0;
        n_pass  = 0;
        sel     = 1'b0;
        t_valid = 1'b0;
        t_ready = 1'b0;
        t_addr  = 32'h0;
        t_we    = 1'b0;
        t_be    = 4'h0;
        t_wdata = 32'h0;
        rst_n   = 1'b0;

        vecs[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,  4'hF, 32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,  4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h20,  4'h0, 32'h0,        32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0,   4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h22,  4'h0, 32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h400, 4'hF, 32'h12345678, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h2,   4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h0,   4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, 32'h3FC, 4'hF, 32'h0BADCAFE, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h3FC, 4'h0, 32'h0,        32'h0BADCAFE, 1'b0};
        vecs[12] = '{1'b1, 32'h3FC, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h3FC, 4'h0, 32'h0,        32'h0BADCAFE, 1'b0};
        vecs[14] = '{1'b0, 32'h401, 4'h0, 32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b1, 32'h30,  4'hF, 32'h600DF00D, 32'h0,        1'b0};

        #12;
        check("reset.req_ready", 32'(o_req_ready), 32'd1);
        check("reset.rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset.rdata", o_rsp_rdata, 32'd0);
        check("reset.err", 32'(o_rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
        end

        // rsp_ready held high from accept through WAIT must not shorten the transaction.
        do_txn("early_ready", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Response backpressure with a stray store request presented during RESP.
        t_we    = 1'b0;
        t_addr  = 32'h30;
        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        hs = 0;
        while (!o_rsp_valid && hs < 50) begin
            tick();
            hs++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d.rsp_valid", i), 32'(o_rsp_valid), 32'd1);
            check($sformatf("bp%0d.rdata", i), o_rsp_rdata, 32'h600DF00D);
            check($sformatf("bp%0d.err", i), 32'(o_rsp_err), 32'd0);
            check($sformatf("bp%0d.req_ready", i), 32'(o_req_ready), 32'd0);
            if (i == 2) begin
                t_we    = 1'b1;
                t_be    = 4'hF;
                t_wdata = 32'h00000055;
                t_valid = 1'b1;
            end else begin
                t_valid = 1'b0;
            end
            tick();
        end
        t_valid = 1'b0;
        t_ready = 1'b1;
        tick();
        t_ready = 1'b0;
        check("bp.release_ready", 32'(o_req_ready), 32'd1);
        check("bp.release_valid", 32'(o_rsp_valid), 32'd0);
        do_txn("bp.readback", 1'b0, 32'h30, 4'h0, 32'h0, 32'h600DF00D, 1'b0, 1'b0);

        // Reset one cycle after accepting a store: the store must be discarded.
        t_we    = 1'b1;
        t_addr  = 32'h30;
        t_be    = 4'hF;
        t_wdata = 32'h00000055;
        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        tick();
        check("rst.busy_before", 32'(o_req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst.async_ready", 32'(o_req_ready), 32'd1);
        check("rst.async_valid", 32'(o_rsp_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_txn("rst.readback", 1'b0, 32'h30, 4'h0, 32'h0, 32'h600DF00D, 1'b0, 1'b0);

        // Zero-wait-state instance.
        sel = 1'b1;
        #1;
        do_txn("w0.store", 1'b1, 32'h8, 4'hF, 32'h13572468, 32'h0, 1'b0, 1'b0);
        do_txn("w0.load", 1'b0, 32'h8, 4'h0, 32'h0, 32'h13572468, 1'b0, 1'b0);

        t_we    = 1'b0;
        t_addr  = 32'h8;
        t_valid = 1'b1;
        t_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_rsp_valid) begin
                hs++;
                check($sformatf("w0.b2b%0d.rdata", hs), o_rsp_rdata, 32'h13572468);
            end
            tick();
        end
        t_valid = 1'b0;
        check("w0.b2b.count", 32'(hs), 32'd4);
        check("w0.b2b.idle", 32'(o_req_ready), 32'd1);
        t_ready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
